// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_bridge
// Purpose  : Core load/store port to handshaked data bus, with strobes,
//            load extension, stall, fault and load-response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr, r_wdata, r_rdata;
  logic               r_we, r_to_fault;
  logic [2:0]         r_funct3;

  logic        w_illegal, w_misal, w_idle_req, w_bad, w_go;
  logic        w_accept, w_resp, w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext, w_bwdata;
  logic [3:0]  w_strb;

  assign w_illegal  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (mem_we && funct3[2]);
  assign w_misal    = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign w_idle_req = (r_state == S_IDLE) && mem_req;
  assign w_bad      = w_idle_req && (w_illegal || w_misal);
  assign w_go       = w_idle_req && !(w_illegal || w_misal);
  assign w_accept   = (r_state == S_REQ) && bus_ready;
  assign w_resp     = (r_state == S_WAIT) && bus_rvalid;
  // A response in the final counted cycle takes priority over the timeout.
  assign w_timeout  = (r_state == S_WAIT) && !bus_rvalid && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    fault     = 1'b0;
    bus_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        fault = w_bad;
        stall = w_go;
        if (w_go) w_next = S_REQ;
      end
      S_REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) w_next = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        stall = 1'b1;
        if (w_resp || w_timeout) w_next = S_DONE;
      end
      S_DONE: begin
        fault  = r_to_fault;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_strb   = 4'b0000;
    w_bwdata = r_wdata;
    case (r_funct3[1:0])
      2'b00: begin
        w_strb   = 4'b0001 << r_addr[1:0];
        w_bwdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_bwdata = {2{r_wdata[15:0]}};
      end
      default: w_strb = 4'b1111;
    endcase
  end

  always_comb begin
    w_byte = bus_rdata[7:0];
    case (r_addr[1:0])
      2'b01:   w_byte = bus_rdata[15:8];
      2'b10:   w_byte = bus_rdata[23:16];
      2'b11:   w_byte = bus_rdata[31:24];
      default: w_byte = bus_rdata[7:0];
    endcase
    w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = bus_rdata;
    endcase
  end

  assign bus_we    = (r_state == S_REQ) && r_we;
  assign bus_wstrb = bus_we ? w_strb : 4'b0000;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_wdata = w_bwdata;
  assign rdata     = w_bad ? 32'd0 : r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_funct3   <= '0;
      r_rdata    <= '0;
      r_to_fault <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_to_fault <= w_timeout;
      if (w_go) begin
        r_addr   <= addr;
        r_wdata  <= wdata;
        r_we     <= mem_we;
        r_funct3 <= funct3;
      end
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == S_WAIT)
        r_cnt <= r_cnt + CNT_W'(1);
      if (w_resp)
        r_rdata <= w_ext;
      else if (w_timeout)
        r_rdata <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_bus_bridge
// Purpose  : Self-checking bench for lsu_bus_bridge (vectors, corners, random).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_bridge;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic        clk, reset, mem_req, mem_we, bus_ready, bus_rvalid;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        stall, fault, bus_valid, bus_we;
  logic [3:0]  bus_wstrb;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] held_rdata = 32'd0;

  lsu_bus_bridge #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
    .stall(stall), .fault(fault), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          rdy_dly;
    int          rv_dly;
    logic        bad;
    logic [3:0]  e_strb;
    logic [31:0] e_bw;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: access rules computed directly from the width/sign codes.
  function automatic logic m_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return (a % size) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
    int size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    int lo   = a % 4;
    logic [3:0] s = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + size) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_bw(input logic [2:0] f3, input logic [31:0] wd);
    int size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    longint unsigned unit = wd % (64'd1 << (8 * size));
    longint unsigned acc = 0;
    for (int i = 0; i < 4 / size; i++) acc = acc + unit * (64'd1 << (8 * size * i));
    return 32'(acc);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    int lo   = (size == 4) ? 0 : (a % 4) - ((a % 4) % size);
    v = longint'((64'(rd) >> (8 * lo)) % (64'd1 << (8 * size)));
    if (f3 < 4 && size < 4 && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
    return 32'(v);
  endfunction

  task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int rdy_dly, input int rv_dly, input logic bad,
                        input logic [3:0] e_strb, input logic [31:0] e_bw,
                        input logic [31:0] e_rd);
    logic timed_out = 1'b0;
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    bus_ready = 1'($urandom % 2); bus_rvalid = 1'($urandom % 2); bus_rdata = $urandom;
    #1;
    if (bad) begin
      chk("bad_fault", 32'(fault), 32'd1);
      chk("bad_stall", 32'(stall), 32'd0);
      chk("bad_valid", 32'(bus_valid), 32'd0);
      chk("bad_rdata", rdata, 32'd0);
      step();
      mem_req = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
      #1;
      chk("bad_fault_end", 32'(fault), 32'd0);
      chk("bad_valid_end", 32'(bus_valid), 32'd0);
      chk("bad_rdata_held", rdata, held_rdata);
      return;
    end
    chk("idle_stall", 32'(stall), 32'd1);
    chk("idle_fault", 32'(fault), 32'd0);
    chk("idle_valid", 32'(bus_valid), 32'd0);
    step();
    for (int i = 0; i <= rdy_dly; i++) begin
      bus_ready  = (i == rdy_dly);
      bus_rvalid = 1'($urandom % 2);
      #1;
      chk("req_valid", 32'(bus_valid), 32'd1);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_we", 32'(bus_we), 32'(we));
      chk("req_wstrb", 32'(bus_wstrb), 32'(e_strb));
      if (we) chk("req_wdata", bus_wdata, e_bw);
      step();
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    if (!we) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        bus_rvalid = (k == rv_dly);
        bus_rdata  = (k == rv_dly) ? rd : $urandom;
        #1;
        chk("wait_valid", 32'(bus_valid), 32'd0);
        chk("wait_stall", 32'(stall), 32'd1);
        chk("wait_fault", 32'(fault), 32'd0);
        step();
        if (k == rv_dly) break;
        if (k == TIMEOUT - 1) timed_out = 1'b1;
      end
      held_rdata = timed_out ? 32'd0 : e_rd;
    end
    mem_req = 1'b0;
    bus_rvalid = 1'($urandom % 2); bus_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_valid", 32'(bus_valid), 32'd0);
    chk("done_fault", 32'(fault), 32'(timed_out));
    chk("done_rdata", rdata, held_rdata);
    step();
    bus_rvalid = 1'b0;
    #1;
    chk("post_fault", 32'(fault), 32'd0);
    chk("post_stall", 32'(stall), 32'd0);
    chk("post_rdata", rdata, held_rdata);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus_valid), 32'd0);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0, 1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0, 0, 1'b0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[3]  = '{1'b1, 3'b001, 32'h100, 32'h00005A5A, 32'h0, 2, 0, 1'b0, 4'h3, 32'h5A5A5A5A, 32'h0};
    vecs[4]  = '{1'b0, 3'b000, 32'h202, 32'h0, 32'h12F34567, 0, 3, 1'b0, 4'h0, 32'h0, 32'hFFFFFFF3};
    vecs[5]  = '{1'b0, 3'b100, 32'h202, 32'h0, 32'h12F34567, 0, 3, 1'b0, 4'h0, 32'h0, 32'h000000F3};
    vecs[6]  = '{1'b0, 3'b101, 32'h202, 32'h0, 32'h12F34567, 0, 3, 1'b0, 4'h0, 32'h0, 32'h000012F3};
    vecs[7]  = '{1'b0, 3'b001, 32'h202, 32'h0, 32'h82F34567, 1, 0, 1'b0, 4'h0, 32'h0, 32'hFFFF82F3};
    vecs[8]  = '{1'b0, 3'b000, 32'h201, 32'h0, 32'h12F34567, 0, 2, 1'b0, 4'h0, 32'h0, 32'h00000045};
    vecs[9]  = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFEF00D, 0, 0, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D};
    vecs[10] = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 3'b001, 32'h201, 32'h0, 32'h0, 0, 0, 1'b1, 4'h0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 5, 99, 1'b0, 4'h0, 32'h0, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h108, 32'h0, 32'h11223344, 0, TIMEOUT - 1, 1'b0, 4'h0, 32'h0, 32'h11223344};

    reset = 1'b1; mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = 32'h0;
    wdata = 32'h0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    chk_reset_outputs("rst");
    reset = 1'b0;
    step();

    // Bus handshakes with no request pending are ignored.
    for (int i = 0; i < 3; i++) begin
      bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000;
      #1;
      chk("idle_ign_valid", 32'(bus_valid), 32'd0);
      chk("idle_ign_stall", 32'(stall), 32'd0);
      chk("idle_ign_rdata", rdata, 32'd0);
      step();
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;

    for (int v = 0; v < 16; v++)
      run_op(vecs[v].we, vecs[v].f3, vecs[v].a, vecs[v].wd, vecs[v].rd,
             vecs[v].rdy_dly, vecs[v].rv_dly, vecs[v].bad,
             vecs[v].e_strb, vecs[v].e_bw, vecs[v].e_rd);

    // Reset while a load sits in WAIT; the late response must be dropped.
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h300; bus_ready = 1'b1;
    step();
    step();
    mem_req = 1'b0; bus_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    step();
    reset = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    bus_rvalid = 1'b0;
    #1;
    chk_reset_outputs("late_rsp");
    held_rdata = 32'd0;
    run_op(1'b0, 3'b100, 32'h303, 32'h0, 32'h9A000000, 0, 1, 1'b0, 4'h0, 32'h0, 32'h0000009A);

    for (int n = 0; n < 40; n++) begin
      logic        we  = 1'($urandom % 2);
      logic [2:0]  f3  = 3'($urandom % 8);
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      int          rdy = int'($urandom_range(0, 3));
      int          rv  = ($urandom % 8 == 0) ? TIMEOUT + 3 : int'($urandom_range(0, 4));
      run_op(we, f3, a, wd, rd, rdy, rv, m_bad(we, f3, a),
             m_strb(f3, a), m_bw(f3, wd), m_load(f3, a, rd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
Load/store unit between the single-cycle core datapath and a handshaked data-memory bus. It takes the core's ALU address, store data and funct3, and converts them into a word-aligned bus request with byte strobes. It returns the sign- or zero-extended load data on the core's ReadData path and holds the core with a stall output until the access completes. It also detects misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT, 16, max cycles in WAIT before a load is abandoned (>=2)
CNT_W, 5, width of timeout counter (must hold TIMEOUT)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
mem_req  input  1  core issues a load or store this instruction
mem_we  input  1  1=store, 0=load
funct3  input  3  RISC-V width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr  input  32  byte address from ALU
wdata  input  32  store data from register file
rdata  output  32  extended load data to core result mux
stall  output  1  core must hold PC and inputs while high
fault  output  1  one-cycle pulse: misaligned/illegal access or timeout
bus_valid  output  1  request valid
bus_ready  input  1  bus accepts request when valid&ready
bus_we  output  1  write request
bus_addr  output  32  {addr[31:2],2'b00}
bus_wstrb  output  4  byte-lane strobes
bus_wdata  output  32  lane-replicated store data
bus_rvalid  input  1  load response valid
bus_rdata  input  32  load response word

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset state: state=IDLE; counter=0; all latched registers=0.
- Reset output values: bus_valid=0, bus_we=0, bus_wstrb=0, bus_addr=0, bus_wdata=0, rdata=0, fault=0, stall=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, legality check: when mem_req=1, check legality first.
  - Illegal: funct3 in {011,110,111}, or store funct3 with bit2 set.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal or misaligned access: stay in IDLE, fault=1 for that cycle, stall=0, no bus activity, rdata=0.
- IDLE, legal access: latch addr, mem_we, funct3 and wdata; go to REQ. stall=1 combinationally in this same cycle.
- REQ: bus_valid=1; bus outputs driven from latched values and held stable until bus_ready.
  - On valid&ready, a store goes to DONE; a load goes to WAIT with counter cleared.
- WAIT: bus_valid=0. Counter increments each cycle.
  - On bus_rvalid: register the extracted data into rdata and go to DONE.
  - If counter reaches TIMEOUT-1 without bus_rvalid: rdata=0, fault pulses in the DONE cycle, go to DONE.
- DONE: stall=0 for exactly one cycle so the core retires; next state IDLE.
  - rdata holds its value until the next load completes.
- stall rule: stall=1 when (IDLE and legal mem_req), and in REQ and WAIT; otherwise 0.
- Strobes and store data:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 1111, wdata = wdata.
  - Loads drive wstrb=0000.
- Load extraction:
  - Select byte lane addr[1:0] (B/BU) or half lane addr[1] (H/HU) of bus_rdata.
  - B/H sign-extend to 32 bits; BU/HU zero-extend; W passes through.
- Boundary conditions:
  - bus_rvalid outside WAIT is ignored.
  - bus_ready outside REQ is ignored.
  - mem_req=0 in IDLE: no state change.
  - rvalid arriving in the same cycle the counter hits TIMEOUT-1: the response wins, no fault.
- Reset mid-operation: immediate return to IDLE with bus_valid=0. A late response is dropped.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, bus_ready high at first REQ cycle -> bus_addr=0x100, wstrb=1111, stall high 2 cycles then low 1 cycle, fault=0.
- SB addr=0x103 wdata=0x000000A5 -> wstrb=1000, bus_wdata=0xA5A5A5A5.
- LB addr=0x202, bus_rdata=0x12F3_4567, rvalid 3 cycles after accept -> rdata=0xFFFFFFF3. LBU same -> 0x000000F3. LHU addr=0x202 -> 0x000012F3.
- LW addr=0x102 (misaligned) -> fault one-cycle pulse, stall never asserted, bus_valid stays 0. Same result for funct3=011.
- LW with bus_ready held low 5 cycles -> bus_valid, bus_addr and stall held stable; rvalid never arrives -> after TIMEOUT cycles in WAIT, rdata=0, fault pulse, stall drops.
- Assert reset while in WAIT, then pulse bus_rvalid -> all outputs at reset values, rdata unchanged at 0, FSM in IDLE.
